wave_capture_store: RTL and testbench

WAVE_CAPTURE_STORE -- requirements
Module: wave_capture_store

---
 rtl/scope_pkg.sv | 21 ++
 rtl/wave_ram_dp.sv | 31 +++
 rtl/wave_capture_store.sv | 130 +++++++++++++
 tb/tb_wave_capture_store.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared states, defaults and sample helpers for the waveform capture store
package scope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_ARM,
    ST_POST,
    ST_READY
  } state_t;

  localparam int DEF_DEPTH    = 1024;
  localparam int DEF_PRE_TRIG = 512;
  localparam int DEF_AUTO_TO  = 4096;
  localparam int SAMPLE_W     = 12;

  function automatic logic is_extreme(input logic [SAMPLE_W-1:0] s);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/wave_ram_dp.sv
// rtl/wave_ram_dp.sv - simple dual-port sample buffer, one write port, one registered read port
module wave_ram_dp #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Only the read register is reset; the array itself keeps its contents.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wave_capture_store.sv
// rtl/wave_capture_store.sv - decimating triggered capture of ADC samples into a display frame buffer
module wave_capture_store
  import scope_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PRE_TRIG = DEF_PRE_TRIG,
  parameter int AUTO_TO  = DEF_AUTO_TO
) (
  input  logic                     pix_clk,
  input  logic                     sys_rst,
  input  logic [11:0]              ad_data,
  input  logic                     ad_valid,
  input  logic [11:0]              deci_rate,
  input  logic [11:0]              trig_level,
  input  logic                     trig_edge,
  input  logic                     wave_run,
  input  logic                     wave_data_req,
  input  logic [$clog2(DEPTH)-1:0] wave_addr,
  input  logic                     wr_over,
  output logic [11:0]              wave_data,
  output logic                     outrange,
  output logic                     frame_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2((AUTO_TO > DEPTH) ? AUTO_TO : DEPTH) + 1;

  state_t          r_state, w_next;
  logic [11:0]     r_deci_cnt, r_prev;
  logic [AW-1:0]   r_wr_ptr, r_trig_ptr;
  logic [CW-1:0]   r_phase_cnt;
  logic            r_or_sticky, r_outrange;

  logic [11:0]     w_rate;
  logic [AW-1:0]   w_rd_addr;
  logic            w_take, w_capture, w_wr_en, w_extreme, w_edge_hit, w_trig;
  logic            w_last_pre, w_last_post, w_enter_pre, w_enter_ready;

  assign w_rate      = (deci_rate == 12'd0) ? 12'd1 : deci_rate;
  assign w_take      = ad_valid && (r_deci_cnt >= w_rate - 12'd1);
  assign w_capture   = r_state inside {ST_PRE_FILL, ST_ARM, ST_POST};
  assign w_wr_en     = w_take && w_capture;
  assign w_extreme   = is_extreme(ad_data);
  assign w_edge_hit  = trig_edge ? ((r_prev > trig_level) && (ad_data <= trig_level))
                                 : ((r_prev < trig_level) && (ad_data >= trig_level));
  assign w_trig      = w_edge_hit || (r_phase_cnt == CW'(AUTO_TO - 1));
  assign w_last_pre  = r_phase_cnt == CW'(PRE_TRIG - 1);
  assign w_last_post = r_phase_cnt == CW'(DEPTH - PRE_TRIG - 1);

  always_ff @(posedge pix_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Dropping wave_run abandons a capture; a take in that same cycle still lands in RAM.
  always_comb begin
    w_next        = r_state;
    w_enter_pre   = 1'b0;
    w_enter_ready = 1'b0;
    case (r_state)
      ST_IDLE:     if (wave_run) w_next = ST_PRE_FILL;
      ST_PRE_FILL: if (!wave_run) w_next = ST_IDLE;
                   else if (w_take && w_last_pre) w_next = ST_ARM;
      ST_ARM:      if (!wave_run) w_next = ST_IDLE;
                   else if (w_take && w_trig) w_next = ST_POST;
      ST_POST:     if (!wave_run) w_next = ST_IDLE;
                   else if (w_take && w_last_post) w_next = ST_READY;
      ST_READY:    if (wr_over && wave_run) w_next = ST_PRE_FILL;
      default:     w_next = ST_IDLE;
    endcase
    w_enter_pre   = (w_next == ST_PRE_FILL) && (r_state != ST_PRE_FILL);
    w_enter_ready = (w_next == ST_READY) && (r_state != ST_READY);
  end

  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      r_deci_cnt  <= '0;
      r_prev      <= '0;
      r_wr_ptr    <= '0;
      r_trig_ptr  <= '0;
      r_phase_cnt <= '0;
      r_or_sticky <= 1'b0;
      r_outrange  <= 1'b0;
    end else begin
      if (w_enter_pre)   r_deci_cnt <= '0;
      else if (ad_valid) r_deci_cnt <= w_take ? 12'd0 : r_deci_cnt + 12'd1;

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_prev   <= ad_data;
      end

      // Phase count restarts per state; POST starts at 1 because the trigger sample counts.
      if (w_enter_pre) r_phase_cnt <= '0;
      else if (w_wr_en) begin
        case (r_state)
          ST_PRE_FILL: r_phase_cnt <= w_last_pre ? '0 : r_phase_cnt + CW'(1);
          ST_ARM:      r_phase_cnt <= w_trig ? CW'(1) : r_phase_cnt + CW'(1);
          default:     r_phase_cnt <= r_phase_cnt + CW'(1);
        endcase
      end

      if (w_wr_en && (r_state == ST_ARM) && w_trig) r_trig_ptr <= r_wr_ptr;

      if (w_enter_pre)             r_or_sticky <= 1'b0;
      else if (w_wr_en && w_extreme) r_or_sticky <= 1'b1;

      if (w_enter_ready) r_outrange <= r_or_sticky | w_extreme;
    end
  end

  assign w_rd_addr   = r_trig_ptr - AW'(PRE_TRIG) + wave_addr;
  assign outrange    = r_outrange;
  assign frame_ready = (r_state == ST_READY);

  wave_ram_dp #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_ram (
    .i_clk     (pix_clk),
    .i_rst     (sys_rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (ad_data),
    .i_rd_en   (wave_data_req),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (wave_data)
  );

endmodule

// File: tb/tb_wave_capture_store.sv
// tb/tb_wave_capture_store.sv - randomized self-checking bench for wave_capture_store
module tb_wave_capture_store;

  localparam int DEPTH    = 1024;
  localparam int PRE_TRIG = 512;
  localparam int AUTO_TO  = 4096;

  logic        pix_clk = 1'b0;
  logic        sys_rst, ad_valid, trig_edge, wave_run, wave_data_req, wr_over;
  logic [11:0] ad_data, deci_rate, trig_level, wave_data;
  logic [9:0]  wave_addr;
  logic        outrange, frame_ready;

  always #5 pix_clk = ~pix_clk;

  wave_capture_store dut (
    .pix_clk       (pix_clk),
    .sys_rst       (sys_rst),
    .ad_data       (ad_data),
    .ad_valid      (ad_valid),
    .deci_rate     (deci_rate),
    .trig_level    (trig_level),
    .trig_edge     (trig_edge),
    .wave_run      (wave_run),
    .wave_data_req (wave_data_req),
    .wave_addr     (wave_addr),
    .wr_over       (wr_over),
    .wave_data     (wave_data),
    .outrange      (outrange),
    .frame_ready   (frame_ready)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          takes[$];
  int          trig_idx, exp_ready_cyc, dut_ready_cyc, ramp_start;
  logic [11:0] got[DEPTH];

  function automatic int sine_at(input int k);
    int v;
    v = $rtoi(2048.0 + 2047.0 * $sin(6.283185307179586 * real'(k) / 200.0) + 0.5);
    if (v > 4095) v = 4095;
    if (v < 0) v = 0;
    return v;
  endfunction

  function automatic int gen_sample(input int mode, input int k);
    case (mode)
      0:       return (ramp_start + k) % 4096;
      1:       return 1000;
      2:       return sine_at(k);
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic int exp_word(input int a);
    int i;
    i = trig_idx - PRE_TRIG + a;
    if (trig_idx < 0 || i < 0 || i >= takes.size()) return -1;
    return takes[i];
  endfunction

  function automatic bit model_outrange();
    for (int i = 0; i < trig_idx + DEPTH - PRE_TRIG && i < takes.size(); i++)
      if (takes[i] == 0 || takes[i] == 4095) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one capture from IDLE or READY and builds the expected frame from the list of kept samples.
  task automatic do_capture(input int mode, input int rate, input int vpct, input int level,
                            input bit fall, input int stop_takes, input int max_cycles);
    int nvalid, eff, v, i, gen_k;
    bit hit;
    eff = (rate == 0) ? 1 : rate;
    takes.delete();
    trig_idx = -1; exp_ready_cyc = -1; dut_ready_cyc = -1; gen_k = 0; nvalid = 0;
    @(negedge pix_clk);
    deci_rate = 12'(rate); trig_level = 12'(level); trig_edge = fall;
    wave_run = 1'b1; wr_over = 1'b1; ad_valid = 1'b0; wave_data_req = 1'b0;
    @(negedge pix_clk);
    wr_over = 1'b0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      if (cyc != 0) @(negedge pix_clk);
      if (frame_ready === 1'b1 && dut_ready_cyc < 0) dut_ready_cyc = cyc;
      if (stop_takes > 0 && takes.size() >= stop_takes) break;
      if (dut_ready_cyc >= 0 && exp_ready_cyc >= 0) break;
      v = gen_sample(mode, gen_k);
      ad_valid = ($urandom_range(0, 99) < vpct);
      ad_data = 12'(v);
      if (ad_valid) begin
        gen_k++; nvalid++;
        if (nvalid % eff == 0 && exp_ready_cyc < 0) begin
          takes.push_back(v);
          i = takes.size() - 1;
          if (trig_idx < 0 && i >= PRE_TRIG) begin
            hit = fall ? (takes[i-1] > level && takes[i] <= level)
                       : (takes[i-1] < level && takes[i] >= level);
            if (hit || (i - PRE_TRIG + 1 == AUTO_TO)) trig_idx = i;
          end
          if (trig_idx >= 0 && takes.size() == trig_idx + DEPTH - PRE_TRIG) exp_ready_cyc = cyc + 1;
        end
      end
    end
    ad_valid = 1'b0;
  endtask

  task automatic read_frame();
    for (int a = 0; a <= DEPTH; a++) begin
      @(negedge pix_clk);
      if (a > 0) got[a-1] = wave_data;
      if (a < DEPTH) begin
        wave_addr = 10'(a);
        wave_data_req = 1'b1;
      end else begin
        wave_data_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; ad_valid = 0; ad_data = 0; deci_rate = 0; trig_level = 0; trig_edge = 0;
    wave_run = 0; wave_data_req = 0; wave_addr = 0; wr_over = 0;
    repeat (3) @(negedge pix_clk);
    n_cmp++; if (wave_data !== 12'd0) begin n_bad++; $display("FAIL reset_wave_data: got %0d want 0", wave_data); end
    n_cmp++; if (outrange !== 1'b0) begin n_bad++; $display("FAIL reset_outrange: got %b want 0", outrange); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
    sys_rst = 1'b0;
  endtask

  task automatic test_ramp_full_rate();
    int bad, fa;
    ramp_start = $urandom_range(0, 1000);
    do_capture(0, 0, 100, 2000, 1'b0, 0, 20000);
    n_cmp++; if (dut_ready_cyc !== exp_ready_cyc || exp_ready_cyc < 0) begin n_bad++; $display("FAIL ramp_ready_cycle: got %0d want %0d", dut_ready_cyc, exp_ready_cyc); end
    read_frame();
    bad = 0; fa = 0;
    for (int a = 0; a < DEPTH; a++) if (got[a] !== 12'(exp_word(a)) || exp_word(a) < 0) begin if (bad == 0) fa = a; bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ramp_frame: %0d words wrong, addr %0d got %0d want %0d", bad, fa, got[fa], exp_word(fa)); end
    n_cmp++; if (got[512] !== 12'd2000) begin n_bad++; $display("FAIL ramp_trig_word: got %0d want 2000", got[512]); end
    n_cmp++; if (got[0] !== 12'd1488) begin n_bad++; $display("FAIL ramp_oldest_word: got %0d want 1488", got[0]); end
    n_cmp++; if (outrange !== model_outrange()) begin n_bad++; $display("FAIL ramp_outrange: got %b want %b", outrange, model_outrange()); end
    wave_addr = 10'd7;
    repeat (3) @(negedge pix_clk);
    n_cmp++; if (wave_data !== 12'(exp_word(DEPTH-1))) begin n_bad++; $display("FAIL read_hold: got %0d want %0d", wave_data, exp_word(DEPTH-1)); end
  endtask

  task automatic test_ramp_decimated();
    int bad, fa;
    ramp_start = $urandom_range(0, 4095);
    do_capture(0, 4, 80, 2000, 1'b0, 0, 40000);
    n_cmp++; if (dut_ready_cyc !== exp_ready_cyc || exp_ready_cyc < 0) begin n_bad++; $display("FAIL deci_ready_cycle: got %0d want %0d", dut_ready_cyc, exp_ready_cyc); end
    read_frame();
    bad = 0; fa = 0;
    for (int a = 0; a < DEPTH; a++) if (got[a] !== 12'(exp_word(a)) || exp_word(a) < 0) begin if (bad == 0) fa = a; bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL deci_frame: %0d words wrong, addr %0d got %0d want %0d", bad, fa, got[fa], exp_word(fa)); end
    n_cmp++; if (!(got[512] >= 12'd2000 && got[512] < 12'd2004)) begin n_bad++; $display("FAIL deci_trig_word: got %0d want 2000..2003", got[512]); end
    n_cmp++; if (12'(got[301] - got[300]) !== 12'd4) begin n_bad++; $display("FAIL deci_step: got %0d want 4", 12'(got[301] - got[300])); end
    n_cmp++; if (outrange !== model_outrange()) begin n_bad++; $display("FAIL deci_outrange: got %b want %b", outrange, model_outrange()); end
  endtask

  task automatic test_forced_trigger();
    int bad, fa;
    do_capture(1, 1, 70, 2000, 1'b0, 0, 12000);
    n_cmp++; if (dut_ready_cyc !== exp_ready_cyc || exp_ready_cyc < 0) begin n_bad++; $display("FAIL forced_ready_cycle: got %0d want %0d", dut_ready_cyc, exp_ready_cyc); end
    read_frame();
    bad = 0; fa = 0;
    for (int a = 0; a < DEPTH; a++) if (got[a] !== 12'd1000) begin if (bad == 0) fa = a; bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL forced_frame: %0d words wrong, addr %0d got %0d want 1000", bad, fa, got[fa]); end
    n_cmp++; if (outrange !== 1'b0) begin n_bad++; $display("FAIL forced_outrange: got %b want 0", outrange); end
  endtask

  task automatic test_sine_falling();
    int bad, fa, lvl;
    lvl = $urandom_range(500, 3500);
    do_capture(2, 1, 90, lvl, 1'b1, 0, 10000);
    n_cmp++; if (dut_ready_cyc !== exp_ready_cyc || exp_ready_cyc < 0) begin n_bad++; $display("FAIL sine_ready_cycle: got %0d want %0d", dut_ready_cyc, exp_ready_cyc); end
    read_frame();
    bad = 0; fa = 0;
    for (int a = 0; a < DEPTH; a++) if (got[a] !== 12'(exp_word(a)) || exp_word(a) < 0) begin if (bad == 0) fa = a; bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL sine_frame: %0d words wrong, addr %0d got %0d want %0d", bad, fa, got[fa], exp_word(fa)); end
    n_cmp++; if (!(int'(got[511]) > lvl && int'(got[512]) <= lvl)) begin n_bad++; $display("FAIL sine_falling_point: got %0d,%0d want >%0d then <=%0d", got[511], got[512], lvl, lvl); end
    n_cmp++; if (outrange !== 1'b1) begin n_bad++; $display("FAIL sine_outrange: got %b want 1", outrange); end
  endtask

  task automatic test_abort_post();
    bit seen;
    ramp_start = 0;
    do_capture(0, 1, 100, 2000, 1'b0, 2200, 5000);
    wave_run = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge pix_clk);
      if (frame_ready !== 1'b0) seen = 1'b1;
      ad_valid = 1'b1; ad_data = 12'($urandom_range(0, 4095));
    end
    ad_valid = 1'b0;
    n_cmp++; if (seen) begin n_bad++; $display("FAIL abort_frame_ready: got 1 want 0"); end
    n_cmp++; if (outrange !== 1'b1) begin n_bad++; $display("FAIL abort_outrange_kept: got %b want 1", outrange); end
  endtask

  task automatic test_reset_in_arm();
    do_capture(1, 1, 100, 2000, 1'b0, 700, 3000);
    sys_rst = 1'b1; wr_over = 1'b1;
    @(negedge pix_clk);
    n_cmp++; if (wave_data !== 12'd0) begin n_bad++; $display("FAIL arm_reset_wave_data: got %0d want 0", wave_data); end
    n_cmp++; if (outrange !== 1'b0) begin n_bad++; $display("FAIL arm_reset_outrange: got %b want 0", outrange); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL arm_reset_frame_ready: got %b want 0", frame_ready); end
    sys_rst = 1'b0; wr_over = 1'b0; wave_run = 1'b0;
  endtask

  task automatic test_ready_hold();
    int bad, fa;
    bit dropped;
    do_capture(3, $urandom_range(1, 3), 75, $urandom_range(1000, 3000), 1'($urandom_range(0, 1)), 0, 10000);
    n_cmp++; if (dut_ready_cyc !== exp_ready_cyc || exp_ready_cyc < 0) begin n_bad++; $display("FAIL hold_ready_cycle: got %0d want %0d", dut_ready_cyc, exp_ready_cyc); end
    wave_run = 1'b0; wr_over = 1'b1;
    dropped = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge pix_clk);
      if (frame_ready !== 1'b1) dropped = 1'b1;
      wr_over = 1'b0;
      if (c == 100) wave_run = 1'b1;
      ad_valid = 1'b1; ad_data = 12'($urandom_range(0, 4095));
    end
    ad_valid = 1'b0;
    n_cmp++; if (dropped) begin n_bad++; $display("FAIL hold_stays_ready: got left READY want stay"); end
    read_frame();
    bad = 0; fa = 0;
    for (int a = 0; a < DEPTH; a++) if (got[a] !== 12'(exp_word(a)) || exp_word(a) < 0) begin if (bad == 0) fa = a; bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL hold_frame: %0d words wrong, addr %0d got %0d want %0d", bad, fa, got[fa], exp_word(fa)); end
    n_cmp++; if (outrange !== model_outrange()) begin n_bad++; $display("FAIL hold_outrange: got %b want %b", outrange, model_outrange()); end
  endtask

  task automatic test_back_to_back();
    int bad, fa;
    for (int r = 0; r < 2; r++) begin
      do_capture(3, $urandom_range(0, 3), 60 + 20 * r, $urandom_range(500, 3500), 1'($urandom_range(0, 1)), 0, 10000);
      n_cmp++; if (dut_ready_cyc !== exp_ready_cyc || exp_ready_cyc < 0) begin n_bad++; $display("FAIL b2b_ready_cycle[%0d]: got %0d want %0d", r, dut_ready_cyc, exp_ready_cyc); end
      read_frame();
      bad = 0; fa = 0;
      for (int a = 0; a < DEPTH; a++) if (got[a] !== 12'(exp_word(a)) || exp_word(a) < 0) begin if (bad == 0) fa = a; bad++; end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_frame[%0d]: %0d words wrong, addr %0d got %0d want %0d", r, bad, fa, got[fa], exp_word(fa)); end
      n_cmp++; if (outrange !== model_outrange()) begin n_bad++; $display("FAIL b2b_outrange[%0d]: got %b want %b", r, outrange, model_outrange()); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_full_rate();
    test_ramp_decimated();
    test_forced_trigger();
    test_sine_falling();
    test_abort_post();
    test_reset_in_arm();
    test_ready_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
